// File: rtl/counter_n_mod.sv
// counter_n_mod: up/down counter over 0..MAX with variable step,
// selectable modulo-wrap or saturate at the bounds, a one-cycle
// crossing pulse (wrap) and a sticky crossing flag (ovf).
module counter_n_mod #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 2,
  parameter int MAX    = 2**WIDTH-1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              nE,
  input  logic              nLoad,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              ovf,
  output logic              at_max,
  output logic              at_zero
);

  // One extra bit so sums/differences never truncate before the bound test.
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] MOD_X = MAX_X + 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             ovf_q,   ovf_d;

  logic [WIDTH:0] cnt_x, stp_x, stp_m, sum_x, up_w, dn_w, nxt_x;
  logic           unused_top;

  // Next-state: load > enable > hold. Modulo results reduce the step by
  // MOD_X first, so steps larger than MAX+1 still wrap correctly.
  always_comb begin
    cnt_x   = {1'b0, count_q};
    stp_x   = (WIDTH+1)'(step);
    stp_m   = stp_x % MOD_X;
    sum_x   = cnt_x + stp_x;
    up_w    = cnt_x + stp_m;
    if (up_w >= MOD_X) up_w = up_w - MOD_X;
    dn_w    = cnt_x + MOD_X - stp_m;
    if (dn_w >= MOD_X) dn_w = dn_w - MOD_X;
    nxt_x   = cnt_x;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (!nLoad) begin
      nxt_x = ({1'b0, load_val} > MAX_X) ? MAX_X : {1'b0, load_val};
      ovf_d = 1'b0;
    end else if (!nE) begin
      if (up) begin
        if (sum_x > MAX_X) begin
          nxt_x  = sat ? MAX_X : up_w;
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          nxt_x  = sum_x;
        end
      end else begin
        if (stp_x > cnt_x) begin
          nxt_x  = sat ? '0 : dn_w;
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          nxt_x  = cnt_x - stp_x;
        end
      end
    end
    count_d = nxt_x[WIDTH-1:0];
  end

  // Results are always <= MAX, so the carry bit is never needed here.
  assign unused_top = nxt_x[WIDTH];

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign ovf     = ovf_q;
  assign at_max  = (count_q == MAX_X[WIDTH-1:0]);
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_counter_n_mod.sv
// Bench for counter_n_mod (WIDTH=4, STEP_W=2, MAX=9): directed scenarios
// followed by random traffic, all checked against an arithmetic model.
module tb_counter_n_mod;
  localparam int W = 4, SW = 2, MX = 9;

  logic          clk = 1'b0;
  logic          nReset, nE, nLoad, up, sat;
  logic [W-1:0]  load_val;
  logic [SW-1:0] step;
  logic [W-1:0]  count;
  logic          wrap, ovf, at_max, at_zero;

  int nassert = 0, nfail = 0;
  int m_cnt = 0, m_wrap = 0, m_ovf = 0;

  counter_n_mod #(.WIDTH(W), .STEP_W(SW), .MAX(MX)) dut (
    .clk(clk), .nReset(nReset), .nE(nE), .nLoad(nLoad), .load_val(load_val),
    .up(up), .step(step), .sat(sat), .count(count), .wrap(wrap), .ovf(ovf),
    .at_max(at_max), .at_zero(at_zero));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"},   32'(count),   32'(m_cnt));
    chk({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
    chk({tag, ".ovf"},     32'(ovf),     32'(m_ovf));
    chk({tag, ".at_max"},  32'(at_max),  32'(m_cnt == MX));
    chk({tag, ".at_zero"}, 32'(at_zero), 32'(m_cnt == 0));
  endtask

  // Reference: plain modular arithmetic over 0..MX.
  task automatic model(input int e_n, input int l_n, input int lv, input int u,
                       input int s, input int st);
    int t;
    if (l_n == 0) begin
      m_cnt = (lv > MX) ? MX : lv; m_wrap = 0; m_ovf = 0;
    end else if (e_n == 0) begin
      t = u ? m_cnt + s : m_cnt - s;
      if (t > MX || t < 0) begin
        m_wrap = 1; m_ovf = 1;
        if (st) m_cnt = (t > MX) ? MX : 0;
        else    m_cnt = ((t % (MX+1)) + (MX+1)) % (MX+1);
      end else begin
        m_cnt = t; m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // One clock: drive, edge, update model, check 1 time unit later.
  task automatic cyc(input string tag, input int e_n, input int l_n, input int lv,
                     input int u, input int s, input int st);
    nE = 1'(e_n); nLoad = 1'(l_n); load_val = W'(lv); up = 1'(u);
    step = SW'(s); sat = 1'(st);
    @(posedge clk);
    model(e_n, l_n, lv, u, s, st);
    #1;
    chk_all(tag);
  endtask

  initial begin
    nReset = 1'b0; nE = 1'b1; nLoad = 1'b1; load_val = '0; up = 1'b1;
    step = '0; sat = 1'b0;
    #12;
    chk_all("reset");
    @(negedge clk); nReset = 1'b1;
    @(posedge clk); #1;

    // Count 1..9,0,1,2 with a single crossing at 9->0.
    for (int i = 1; i <= 12; i++) begin
      cyc("up1", 0, 1, 0, 1, 1, 0);
      chk("up1.lit_count", 32'(count), 32'(i % 10));
      chk("up1.lit_wrap",  32'(wrap),  32'(i == 10));
      chk("up1.lit_ovf",   32'(ovf),   32'(i >= 10));
    end

    // Wrap up by 3 from 8.
    cyc("ld8", 1, 0, 8, 1, 0, 0);
    cyc("up3a", 0, 1, 0, 1, 3, 0);
    chk("up3a.lit", 32'({count, wrap}), 32'({4'd1, 1'b1}));
    cyc("up3b", 0, 1, 0, 1, 3, 0);
    chk("up3b.lit", 32'({count, wrap}), 32'({4'd4, 1'b0}));

    // Saturate at zero, repeat attempt, then clamp load of 15.
    cyc("ld2", 1, 0, 2, 0, 0, 1);
    cyc("sat0a", 0, 1, 0, 0, 3, 1);
    chk("sat0a.lit", 32'({count, wrap}), 32'({4'd0, 1'b1}));
    cyc("sat0b", 0, 1, 0, 0, 3, 1);
    chk("sat0b.lit", 32'({count, wrap}), 32'({4'd0, 1'b1}));
    cyc("ld15", 1, 0, 15, 0, 3, 1);
    chk("ld15.lit", 32'({count, ovf, at_max}), 32'({4'd9, 1'b0, 1'b1}));
    // Saturate at MAX in the up direction, and step 0 is no crossing.
    cyc("satmx", 0, 1, 0, 1, 2, 1);
    chk("satmx.lit", 32'({count, wrap}), 32'({4'd9, 1'b1}));
    cyc("step0", 0, 1, 0, 1, 0, 0);
    chk("step0.lit", 32'(wrap), 32'(0));

    // Down by 2 from 5: 3,1,9,7.
    cyc("ld5", 1, 0, 5, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("dn2", 0, 1, 0, 0, 2, 0);
    chk("dn2.lit", 32'(count), 32'(7));

    // Hold with inputs toggling, then load beats enable.
    for (int i = 0; i < 5; i++) cyc("hold", 1, 1, 0, i & 1, i % 4, i & 1);
    chk("hold.lit", 32'(count), 32'(7));
    cyc("ldwin", 0, 0, 3, 1, 3, 0);
    chk("ldwin.lit", 32'(count), 32'(3));

    // Async reset between edges mid-count.
    cyc("pre", 0, 1, 0, 1, 3, 0);
    cyc("pre", 0, 1, 0, 1, 3, 0);
    @(negedge clk); #1;
    nReset = 1'b0; #1;
    m_cnt = 0; m_wrap = 0; m_ovf = 0;
    chk_all("async_rst");
    #1; nReset = 1'b1;
    cyc("post_rst", 0, 1, 0, 1, 1, 0);
    chk("post_rst.lit", 32'(count), 32'(1));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 4) == 0) ? 1 : 0,
          ($urandom_range(0, 9) == 0) ? 0 : 1, $urandom_range(0, 15),
          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
